// File: rtl/surf_link_align_if.sv
// Bus bundle between surf_link_align and the PHY/control side.
// eye_map_o exists only when SURF_LINK_ALIGN_EYE_MAP_EN is defined.
interface surf_link_align_if #(
  parameter int NCHAN    = 2,
  parameter int DWIDTH   = 8,
  parameter int DLY_BITS = 5
);
  logic                          start_i;
  logic [NCHAN*DWIDTH-1:0]       data_i;
  logic [DLY_BITS-1:0]           idelay_value_o;
  logic [NCHAN-1:0]              idelay_load_o;
  logic [NCHAN-1:0]              bitslip_o;
  logic                          busy_o;
  logic                          done_o;
  logic [NCHAN-1:0]              locked_o;
  logic [NCHAN-1:0]              fail_o;
  logic [NCHAN*DLY_BITS-1:0]     eye_center_o;
`ifdef SURF_LINK_ALIGN_EYE_MAP_EN
  logic [NCHAN*(2**DLY_BITS)-1:0] eye_map_o;

  modport master (
    output start_i, data_i,
    input  idelay_value_o, idelay_load_o, bitslip_o, busy_o, done_o,
           locked_o, fail_o, eye_center_o, eye_map_o
  );

  modport slave (
    input  start_i, data_i,
    output idelay_value_o, idelay_load_o, bitslip_o, busy_o, done_o,
           locked_o, fail_o, eye_center_o, eye_map_o
  );
`else
  modport master (
    output start_i, data_i,
    input  idelay_value_o, idelay_load_o, bitslip_o, busy_o, done_o,
           locked_o, fail_o, eye_center_o
  );

  modport slave (
    input  start_i, data_i,
    output idelay_value_o, idelay_load_o, bitslip_o, busy_o, done_o,
           locked_o, fail_o, eye_center_o
  );
`endif
endinterface

// File: rtl/surf_link_align.sv
// Sequential per-lane IDELAY eye sweep, centre load and bitslip word lock.
// Optional per-tap eye map output: define SURF_LINK_ALIGN_EYE_MAP_EN.
module surf_link_align #(
  parameter int                NCHAN         = 2,
  parameter int                DWIDTH        = 8,
  parameter logic [DWIDTH-1:0] TRAIN_PATTERN = 8'hA6,
  parameter int                DLY_BITS      = 5,
  parameter int                SETTLE_CYCLES = 16,
  parameter int                SAMPLE_CYCLES = 64,
  parameter int                MIN_EYE       = 4,
  parameter int                SLIP_WAIT     = 4
) (
  input  logic              sysclk_i,
  input  logic              rst_n_i,
  surf_link_align_if.slave  bus
);

  localparam int NTAPS    = 2**DLY_BITS;
  localparam int LANE_W   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int LEN_W    = DLY_BITS + 1;
  localparam int SLIP_MAX = 2*DWIDTH;
  localparam int SLIP_W   = $clog2(SLIP_MAX + 1);
  localparam int CNT_A    = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_MAX  = (CNT_A > SLIP_WAIT) ? CNT_A : SLIP_WAIT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [DLY_BITS-1:0] TAP_MAX = {DLY_BITS{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL,
    S_CENTER, S_CSETTLE, S_SLIP_CHECK, S_SLIP_WAIT, S_NEXT_CHAN
  } state_t;

  state_t                    state_reg;
  logic [LANE_W-1:0]         lane_reg;
  logic [DLY_BITS-1:0]       tap_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [DWIDTH-1:0]         mask_reg;
  logic [DLY_BITS-1:0]       cur_start_reg;
  logic [LEN_W-1:0]          cur_len_reg;
  logic [DLY_BITS-1:0]       best_start_reg;
  logic [LEN_W-1:0]          best_len_reg;
  logic [SLIP_W-1:0]         slips_reg;

  logic [DLY_BITS-1:0]       idelay_value_reg;
  logic [NCHAN-1:0]          idelay_load_reg;
  logic [NCHAN-1:0]          bitslip_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic [NCHAN-1:0]          locked_reg;
  logic [NCHAN-1:0]          fail_reg;
  logic [NCHAN*DLY_BITS-1:0] eye_center_reg;
`ifdef SURF_LINK_ALIGN_EYE_MAP_EN
  logic [NCHAN*NTAPS-1:0]    eye_map_reg;
`endif

  logic [DWIDTH-1:0]         lane_words [NCHAN];
  logic [DWIDTH-1:0]         lane_word;
  logic [DWIDTH-1:0]         rot_match;
  logic [NCHAN-1:0]          lane_oh;
  logic                      tap_good;
  logic [LEN_W-1:0]          run_len_next;
  logic [DLY_BITS-1:0]       run_start_next;
  logic [DLY_BITS-1:0]       centre;

  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_lane
      assign lane_words[gi] = bus.data_i[gi*DWIDTH +: DWIDTH];
      assign lane_oh[gi]    = (lane_reg == LANE_W'(gi));
    end
    // rot_match[r] flags the current lane word as TRAIN_PATTERN rotated left by r
    for (gi = 0; gi < DWIDTH; gi++) begin : g_rot
      localparam logic [DWIDTH-1:0] ROT =
        (TRAIN_PATTERN << gi) | (TRAIN_PATTERN >> (DWIDTH - gi));
      assign rot_match[gi] = (lane_word == ROT);
    end
  endgenerate

  assign lane_word      = lane_words[lane_reg];
  // A rotation survives the window only if it matched every sample; any survivor means a good tap.
  assign tap_good       = |mask_reg;
  assign run_len_next   = cur_len_reg + LEN_W'(1);
  assign run_start_next = (cur_len_reg == '0) ? tap_reg : cur_start_reg;
  assign centre         = best_start_reg + DLY_BITS'((best_len_reg - LEN_W'(1)) >> 1);

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg        <= S_IDLE;
      lane_reg         <= '0;
      tap_reg          <= '0;
      cnt_reg          <= '0;
      mask_reg         <= '0;
      cur_start_reg    <= '0;
      cur_len_reg      <= '0;
      best_start_reg   <= '0;
      best_len_reg     <= '0;
      slips_reg        <= '0;
      idelay_value_reg <= '0;
      idelay_load_reg  <= '0;
      bitslip_reg      <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      locked_reg       <= '0;
      fail_reg         <= '0;
      eye_center_reg   <= '0;
`ifdef SURF_LINK_ALIGN_EYE_MAP_EN
      eye_map_reg      <= '0;
`endif
    end else begin
      idelay_load_reg <= '0;
      bitslip_reg     <= '0;
      done_reg        <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start_i) begin
            lane_reg       <= '0;
            tap_reg        <= '0;
            cur_len_reg    <= '0;
            cur_start_reg  <= '0;
            best_len_reg   <= '0;
            best_start_reg <= '0;
            slips_reg      <= '0;
            locked_reg     <= '0;
            fail_reg       <= '0;
            eye_center_reg <= '0;
`ifdef SURF_LINK_ALIGN_EYE_MAP_EN
            eye_map_reg    <= '0;
`endif
            busy_reg       <= 1'b1;
            state_reg      <= S_LOAD;
          end
        end
        S_LOAD: begin
          idelay_value_reg <= tap_reg;
          idelay_load_reg  <= lane_oh;
          cnt_reg          <= '0;
          state_reg        <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_reg   <= '0;
            mask_reg  <= '1;
            state_reg <= S_SAMPLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          mask_reg <= mask_reg & rot_match;
          if (cnt_reg == CNT_W'(SAMPLE_CYCLES - 1)) begin
            state_reg <= S_EVAL;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_EVAL: begin
          // Strictly-longer replacement keeps the lowest-tap run on a tie.
          if (tap_good) begin
            cur_start_reg <= run_start_next;
            cur_len_reg   <= run_len_next;
            if (run_len_next > best_len_reg) begin
              best_start_reg <= run_start_next;
              best_len_reg   <= run_len_next;
            end
`ifdef SURF_LINK_ALIGN_EYE_MAP_EN
            eye_map_reg[{lane_reg, tap_reg}] <= 1'b1;
`endif
          end else begin
            cur_len_reg <= '0;
          end
          if (tap_reg == TAP_MAX) begin
            state_reg <= S_CENTER;
          end else begin
            tap_reg   <= tap_reg + DLY_BITS'(1);
            state_reg <= S_LOAD;
          end
        end
        S_CENTER: begin
          if (best_len_reg < LEN_W'(MIN_EYE)) begin
            fail_reg[lane_reg] <= 1'b1;
            state_reg          <= S_NEXT_CHAN;
          end else begin
            idelay_value_reg <= centre;
            idelay_load_reg  <= lane_oh;
            eye_center_reg[int'(lane_reg)*DLY_BITS +: DLY_BITS] <= centre;
            cnt_reg          <= '0;
            state_reg        <= S_CSETTLE;
          end
        end
        S_CSETTLE: begin
          if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_reg <= S_SLIP_CHECK;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_SLIP_CHECK: begin
          if (lane_word == TRAIN_PATTERN) begin
            locked_reg[lane_reg] <= 1'b1;
            state_reg            <= S_NEXT_CHAN;
          end else if (slips_reg < SLIP_W'(SLIP_MAX)) begin
            bitslip_reg <= lane_oh;
            slips_reg   <= slips_reg + SLIP_W'(1);
            cnt_reg     <= '0;
            state_reg   <= S_SLIP_WAIT;
          end else begin
            fail_reg[lane_reg] <= 1'b1;
            state_reg          <= S_NEXT_CHAN;
          end
        end
        S_SLIP_WAIT: begin
          if (cnt_reg == CNT_W'(SLIP_WAIT - 1)) begin
            state_reg <= S_SLIP_CHECK;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_NEXT_CHAN: begin
          tap_reg        <= '0;
          cur_len_reg    <= '0;
          cur_start_reg  <= '0;
          best_len_reg   <= '0;
          best_start_reg <= '0;
          slips_reg      <= '0;
          if (lane_reg == LANE_W'(NCHAN - 1)) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            lane_reg  <= lane_reg + LANE_W'(1);
            state_reg <= S_LOAD;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.idelay_value_o = idelay_value_reg;
  assign bus.idelay_load_o  = idelay_load_reg;
  assign bus.bitslip_o      = bitslip_reg;
  assign bus.busy_o         = busy_reg;
  assign bus.done_o         = done_reg;
  assign bus.locked_o       = locked_reg;
  assign bus.fail_o         = fail_reg;
  assign bus.eye_center_o   = eye_center_reg;
`ifdef SURF_LINK_ALIGN_EYE_MAP_EN
  assign bus.eye_map_o      = eye_map_reg;
`endif

endmodule

// File: tb/tb_surf_link_align.sv
// Bench for surf_link_align: a behavioural PHY feeds per-tap training words and
// a run-enumerating reference predicts centre, lock/fail and slip counts.
module tb_surf_link_align;
  localparam int NCHAN    = 2;
  localparam int DWIDTH   = 8;
  localparam int DLY_BITS = 5;
  localparam int NTAPS    = 32;
  localparam logic [7:0] PAT = 8'hA6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  surf_link_align_if #(.NCHAN(NCHAN), .DWIDTH(DWIDTH), .DLY_BITS(DLY_BITS)) bus();

  surf_link_align #(
    .NCHAN(NCHAN), .DWIDTH(DWIDTH), .TRAIN_PATTERN(PAT), .DLY_BITS(DLY_BITS)
  ) dut (
    .sysclk_i (clk),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  int tests_run, tests_failed;
  // PHY environment: mode 0 = noise, 1 = steady rotation, 2 = rotation flips every word
  int mode_tab [NCHAN][NTAPS];
  int rot0 [NCHAN];
  bit slip_live [NCHAN];
  int phy_tap [NCHAN];
  int slip_seen [NCHAN];
  int slip_base [NCHAN];
  int done_seen, done_base, strobe_viol;
  bit flip;

  int exp_center [NCHAN];
  bit exp_lock [NCHAN];
  bit exp_fail [NCHAN];
  int exp_slips [NCHAN];
  logic [NCHAN*NTAPS-1:0] exp_map;

  function automatic logic [7:0] rotl(input logic [7:0] w, input int r);
    return (w << r) | (w >> (8 - r));
  endfunction

  function automatic bit is_rot(input logic [7:0] w);
    for (int r = 0; r < 8; r++) if (rotl(PAT, r) == w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] bad_word();
    logic [7:0] w;
    w = 8'($urandom);
    while (is_rot(w)) w = w + 8'd1;
    return w;
  endfunction

  always @(negedge clk) begin
    int r;
    if ($countones(bus.idelay_load_o) + $countones(bus.bitslip_o) > 1) strobe_viol++;
    if (bus.done_o === 1'b1) done_seen++;
    flip = ~flip;
    for (int n = 0; n < NCHAN; n++) begin
      if (bus.idelay_load_o[n] === 1'b1) phy_tap[n] = int'(bus.idelay_value_o);
      if (bus.bitslip_o[n] === 1'b1) slip_seen[n]++;
      r = slip_live[n] ? (rot0[n] + 64 - (slip_seen[n] - slip_base[n])) % 8 : rot0[n];
      case (mode_tab[n][phy_tap[n]])
        1:       bus.data_i[n*8 +: 8] = rotl(PAT, r);
        2:       bus.data_i[n*8 +: 8] = rotl(PAT, (r + int'(flip)) % 8);
        default: bus.data_i[n*8 +: 8] = bad_word();
      endcase
    end
  end

  task automatic set_lane(input int n, input int lo, input int hi, input int rot, input bit live);
    for (int t = 0; t < NTAPS; t++) mode_tab[n][t] = (t >= lo && t <= hi) ? 1 : 0;
    rot0[n] = rot;
    slip_live[n] = live;
  endtask

  task automatic add_good(input int n, input int lo, input int hi);
    for (int t = lo; t <= hi; t++) mode_tab[n][t] = 1;
  endtask

  // Enumerate maximal good runs; the first longest one defines the eye.
  task automatic model_lanes();
    for (int n = 0; n < NCHAN; n++) begin
      int bs, bl, len;
      bs = 0; bl = 0;
      for (int s = 0; s < NTAPS; s++) begin
        exp_map[n*NTAPS + s] = (mode_tab[n][s] == 1);
        if (mode_tab[n][s] == 1 && (s == 0 || mode_tab[n][s-1] != 1)) begin
          len = 0;
          while (s + len < NTAPS && mode_tab[n][s+len] == 1) len++;
          if (len > bl) begin bl = len; bs = s; end
        end
      end
      if (bl < 4) begin
        exp_center[n] = 0; exp_lock[n] = 0; exp_fail[n] = 1; exp_slips[n] = 0;
      end else begin
        exp_center[n] = bs + (bl - 1) / 2;
        exp_lock[n]   = slip_live[n];
        exp_fail[n]   = !slip_live[n];
        exp_slips[n]  = slip_live[n] ? rot0[n] : 16;
      end
    end
  endtask

  task automatic start_run();
    for (int n = 0; n < NCHAN; n++) slip_base[n] = slip_seen[n];
    done_base = done_seen;
    @(negedge clk); #1 bus.start_i = 1'b1;
    @(negedge clk); #1 bus.start_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_any_load(output int lanes, output int val, output bit ok);
    ok = 1'b0; lanes = 0; val = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (bus.idelay_load_o !== '0) begin
        ok = 1'b1; lanes = int'(bus.idelay_load_o); val = int'(bus.idelay_value_o);
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.busy_o, bus.done_o, bus.locked_o, bus.fail_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_status: got busy=%b done=%b locked=%b fail=%b want all 0",
               bus.busy_o, bus.done_o, bus.locked_o, bus.fail_o);
    end
    tests_run++;
    if ({bus.idelay_load_o, bus.bitslip_o, bus.idelay_value_o, bus.eye_center_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_strobes: got load=%b slip=%b value=%0d centre=%h want all 0",
               bus.idelay_load_o, bus.bitslip_o, bus.idelay_value_o, bus.eye_center_o);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    $display("[TB] reset: checked");
  endtask

  task automatic test_basic_rot3();
    bit ok;
    set_lane(0, 10, 19, 3, 1'b1);
    set_lane(1, 10, 19, 3, 1'b1);
    model_lanes();
    start_run();
    wait_done(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_done: got timeout want done pulse"); end
    for (int n = 0; n < NCHAN; n++) begin
      tests_run++;
      if (bus.eye_center_o[n*5 +: 5] !== 5'd14) begin
        tests_failed++;
        $display("FAIL basic_center lane%0d: got %0d want 14", n, bus.eye_center_o[n*5 +: 5]);
      end
      tests_run++;
      if (slip_seen[n] - slip_base[n] != 3) begin
        tests_failed++;
        $display("FAIL basic_slips lane%0d: got %0d want 3", n, slip_seen[n] - slip_base[n]);
      end
    end
    tests_run++;
    if (bus.locked_o !== 2'b11 || bus.fail_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_lock: got locked=%b fail=%b want 11/00", bus.locked_o, bus.fail_o);
    end
    tests_run++;
    if (done_seen - done_base != 1 || bus.busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_count: got %0d pulses busy=%b want 1 busy=0",
               done_seen - done_base, bus.busy_o);
    end
`ifdef SURF_LINK_ALIGN_EYE_MAP_EN
    tests_run++;
    if (bus.eye_map_o !== exp_map) begin
      tests_failed++;
      $display("FAIL basic_map: got %h want %h", bus.eye_map_o, exp_map);
    end
`endif
    $display("[TB] basic_rot3: centres %0d/%0d locked=%b", bus.eye_center_o[4:0],
             bus.eye_center_o[9:5], bus.locked_o);
  endtask

  task automatic test_tie_nowrap();
    bit ok;
    set_lane(0, 2, 5, int'($urandom_range(0, 7)), 1'b1);
    add_good(0, 20, 23);
    set_lane(1, 28, 31, int'($urandom_range(0, 7)), 1'b1);
    model_lanes();
    start_run();
    wait_done(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL tie_done: got timeout want done pulse"); end
    tests_run++;
    if (bus.eye_center_o[4:0] !== 5'd3) begin
      tests_failed++;
      $display("FAIL tie_center: got %0d want 3", bus.eye_center_o[4:0]);
    end
    tests_run++;
    if (bus.eye_center_o[9:5] !== 5'd29) begin
      tests_failed++;
      $display("FAIL nowrap_center: got %0d want 29", bus.eye_center_o[9:5]);
    end
    for (int n = 0; n < NCHAN; n++) begin
      tests_run++;
      if (slip_seen[n] - slip_base[n] != exp_slips[n] || bus.locked_o[n] !== 1'b1) begin
        tests_failed++;
        $display("FAIL tie_slips lane%0d: got slips=%0d locked=%b want slips=%0d locked=1",
                 n, slip_seen[n] - slip_base[n], bus.locked_o[n], exp_slips[n]);
      end
    end
    $display("[TB] tie_nowrap: centres %0d/%0d", bus.eye_center_o[4:0], bus.eye_center_o[9:5]);
  endtask

  task automatic test_narrow_eye();
    bit ok;
    set_lane(0, 8, 15, int'($urandom_range(0, 7)), 1'b1);
    set_lane(1, 0, 2, 1, 1'b1);
    model_lanes();
    start_run();
    wait_done(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL narrow_done: got timeout want done pulse"); end
    tests_run++;
    if (bus.fail_o !== 2'b10 || bus.locked_o !== 2'b01) begin
      tests_failed++;
      $display("FAIL narrow_flags: got fail=%b locked=%b want 10/01", bus.fail_o, bus.locked_o);
    end
    tests_run++;
    if (slip_seen[1] - slip_base[1] != 0) begin
      tests_failed++;
      $display("FAIL narrow_slips lane1: got %0d want 0", slip_seen[1] - slip_base[1]);
    end
    tests_run++;
    if (bus.eye_center_o[4:0] !== 5'(exp_center[0])) begin
      tests_failed++;
      $display("FAIL narrow_center lane0: got %0d want %0d", bus.eye_center_o[4:0], exp_center[0]);
    end
    $display("[TB] narrow_eye: fail=%b locked=%b", bus.fail_o, bus.locked_o);
  endtask

  task automatic test_no_rotation();
    bit ok;
    set_lane(0, 5, 12, 5, 1'b0);
    set_lane(1, 16, 25, 0, 1'b1);
    model_lanes();
    start_run();
    wait_done(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL norot_done: got timeout want done pulse"); end
    tests_run++;
    if (slip_seen[0] - slip_base[0] != 16) begin
      tests_failed++;
      $display("FAIL norot_slips lane0: got %0d want 16", slip_seen[0] - slip_base[0]);
    end
    tests_run++;
    if (bus.fail_o !== 2'b01 || bus.locked_o !== 2'b10) begin
      tests_failed++;
      $display("FAIL norot_flags: got fail=%b locked=%b want 01/10", bus.fail_o, bus.locked_o);
    end
    tests_run++;
    if (bus.eye_center_o !== {5'(exp_center[1]), 5'(exp_center[0])}) begin
      tests_failed++;
      $display("FAIL norot_center: got %h want %0d/%0d", bus.eye_center_o, exp_center[0], exp_center[1]);
    end
    $display("[TB] no_rotation: slips lane0=%0d", slip_seen[0] - slip_base[0]);
  endtask

  task automatic test_rotation_change();
    bit ok;
    int lanes, val;
    set_lane(0, 8, 20, 2, 1'b1);
    mode_tab[0][12] = 2;
    set_lane(1, 4, 11, 1, 1'b1);
    model_lanes();
    start_run();
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.idelay_load_o[0] === 1'b1 && bus.idelay_value_o == 5'd5) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rotchg_tap5: got timeout want load at tap 5"); end
    @(negedge clk); #1 bus.start_i = 1'b1;
    @(negedge clk); #1 bus.start_i = 1'b0;
    wait_any_load(lanes, val, ok);
    tests_run++;
    if (!ok || lanes != 1 || val != 6) begin
      tests_failed++;
      $display("FAIL busy_start_ignored: got ok=%b lanes=%0d tap=%0d want lanes=1 tap=6", ok, lanes, val);
    end
    wait_done(ok);
    tests_run++;
    if (!ok || done_seen - done_base != 1) begin
      tests_failed++;
      $display("FAIL rotchg_done: got ok=%b pulses=%0d want 1", ok, done_seen - done_base);
    end
    tests_run++;
    if (bus.eye_center_o[4:0] !== 5'd16) begin
      tests_failed++;
      $display("FAIL rotchg_center lane0: got %0d want 16", bus.eye_center_o[4:0]);
    end
    tests_run++;
    if (bus.eye_center_o[9:5] !== 5'(exp_center[1]) || bus.locked_o !== 2'b11) begin
      tests_failed++;
      $display("FAIL rotchg_lane1: got centre=%0d locked=%b want %0d/11",
               bus.eye_center_o[9:5], bus.locked_o, exp_center[1]);
    end
`ifdef SURF_LINK_ALIGN_EYE_MAP_EN
    tests_run++;
    if (bus.eye_map_o !== exp_map) begin
      tests_failed++;
      $display("FAIL rotchg_map: got %h want %h", bus.eye_map_o, exp_map);
    end
`endif
    $display("[TB] rotation_change: centre lane0=%0d", bus.eye_center_o[4:0]);
  endtask

  task automatic test_reset_mid_sweep();
    bit ok;
    int lanes, val;
    set_lane(0, 6, 14, int'($urandom_range(0, 7)), 1'b1);
    set_lane(1, 18, 27, int'($urandom_range(0, 7)), 1'b1);
    model_lanes();
    start_run();
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.idelay_load_o[0] === 1'b1 && bus.idelay_value_o == 5'd7) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL midrst_tap7: got timeout want load at tap 7"); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy_o, bus.done_o, bus.locked_o, bus.fail_o, bus.idelay_load_o, bus.bitslip_o,
         bus.idelay_value_o, bus.eye_center_o} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got busy=%b load=%b value=%0d want all 0",
               bus.busy_o, bus.idelay_load_o, bus.idelay_value_o);
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    start_run();
    wait_any_load(lanes, val, ok);
    tests_run++;
    if (!ok || lanes != 1 || val != 0) begin
      tests_failed++;
      $display("FAIL midrst_restart: got ok=%b lanes=%0d tap=%0d want lanes=1 tap=0", ok, lanes, val);
    end
    wait_done(ok);
    tests_run++;
    if (!ok || bus.eye_center_o !== {5'(exp_center[1]), 5'(exp_center[0])} || bus.locked_o !== 2'b11) begin
      tests_failed++;
      $display("FAIL midrst_result: got ok=%b centre=%h locked=%b want %0d/%0d 11",
               ok, bus.eye_center_o, bus.locked_o, exp_center[0], exp_center[1]);
    end
    $display("[TB] reset_mid_sweep: restarted at tap %0d", val);
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 3; it++) begin
      for (int n = 0; n < NCHAN; n++) begin
        int lo, hi;
        lo = int'($urandom_range(0, 31));
        hi = lo + int'($urandom_range(0, 11));
        if (hi > 31) hi = 31;
        set_lane(n, lo, hi, int'($urandom_range(0, 7)), 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          lo = int'($urandom_range(0, 31));
          hi = lo + int'($urandom_range(0, 7));
          if (hi > 31) hi = 31;
          add_good(n, lo, hi);
        end
      end
      model_lanes();
      start_run();
      wait_done(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL rand%0d_done: got timeout want done pulse", it); end
      for (int n = 0; n < NCHAN; n++) begin
        tests_run++;
        if (bus.eye_center_o[n*5 +: 5] !== 5'(exp_center[n]) ||
            bus.locked_o[n] !== exp_lock[n] || bus.fail_o[n] !== exp_fail[n] ||
            slip_seen[n] - slip_base[n] != exp_slips[n]) begin
          tests_failed++;
          $display("FAIL rand%0d lane%0d: got centre=%0d lock=%b fail=%b slips=%0d want %0d/%b/%b/%0d",
                   it, n, bus.eye_center_o[n*5 +: 5], bus.locked_o[n], bus.fail_o[n],
                   slip_seen[n] - slip_base[n], exp_center[n], exp_lock[n], exp_fail[n], exp_slips[n]);
        end
      end
`ifdef SURF_LINK_ALIGN_EYE_MAP_EN
      tests_run++;
      if (bus.eye_map_o !== exp_map) begin
        tests_failed++;
        $display("FAIL rand%0d_map: got %h want %h", it, bus.eye_map_o, exp_map);
      end
`endif
      $display("[TB] random %0d: centres %0d/%0d locked=%b fail=%b", it,
               bus.eye_center_o[4:0], bus.eye_center_o[9:5], bus.locked_o, bus.fail_o);
    end
  endtask

  task automatic test_strobe_exclusive();
    tests_run++;
    if (strobe_viol != 0) begin
      tests_failed++;
      $display("FAIL strobe_onehot: got %0d cycles with >1 strobe want 0", strobe_viol);
    end
    $display("[TB] strobe_exclusive: checked");
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.data_i  = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_basic_rot3();
    test_tie_nowrap();
    test_narrow_eye();
    test_no_rotation();
    test_rotation_change();
    test_reset_mid_sweep();
    test_random();
    test_strobe_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/surf_link_align.md
Name: surf_link_align

Overview:
- Automatic per-lane receive-alignment controller for multi-lane SURF links (COUT/DOUT-class ISERDES lanes).
- For each lane in turn it:
  - sweeps the IDELAY tap against a fixed training pattern;
  - loads the centre of the widest eye;
  - bitslips until the deserialized word equals the pattern exactly.
- Sits between the per-lane PHY (IDELAY/ISERDES) and the TURFIO control register space.
- Generalises the fixed 2-lane manual-delay/manual-bitslip PHY control to NCHAN lanes of DWIDTH bits, with autonomous lock.

Parameters:
- NCHAN, 2, number of lanes aligned; lanes are processed sequentially, 0 first.
- DWIDTH, 8, deserialized word width per lane.
- TRAIN_PATTERN, 8'hA6, DWIDTH-bit training word.
- DLY_BITS, 5, IDELAY tap field width; sweep covers taps 0..2**DLY_BITS-1.
- SETTLE_CYCLES, 16, wait after any delay load before sampling.
- SAMPLE_CYCLES, 64, consecutive words examined per tap.
- MIN_EYE, 4, minimum good-run length (taps) for lock.
- SLIP_WAIT, 4, cycles after each bitslip pulse before re-checking.

Ports:
- sysclk_i  in  1  sole clock; all logic is synchronous to it.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that starts alignment of all lanes.
- data_i  in  NCHAN*DWIDTH  lane n occupies bits [n*DWIDTH +: DWIDTH].
- idelay_value_o  out  DLY_BITS  tap value, shared by all lanes.
- idelay_load_o  out  NCHAN  one-hot load strobe.
- bitslip_o  out  NCHAN  one-hot bitslip strobe.
- busy_o  out  1  alignment in progress.
- done_o  out  1  one-cycle pulse when the last lane finishes.
- locked_o  out  NCHAN  lane aligned.
- fail_o  out  NCHAN  lane failed (no eye found, or slip limit reached).
- eye_center_o  out  NCHAN*DLY_BITS  tap loaded for each lane.

Behaviour:
- Reset (async assert, synchronous deassert not required internally):
  - all outputs 0; FSM in IDLE.
  - Reset mid-operation aborts immediately; no strobes are emitted afterwards.
- IDLE:
  - start_i goes to LOAD: lane=0, tap=0, locked_o/fail_o/eye_center_o cleared.
  - start_i while busy_o=1 is ignored.
- busy_o is 1 in every state except IDLE.
- LOAD:
  - idelay_value_o=tap and idelay_load_o[lane]=1 for exactly one cycle.
  - Next state SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES, then go to SAMPLE.
- SAMPLE: run for SAMPLE_CYCLES cycles. The tap is good iff both:
  - every sampled word equals some rotation of TRAIN_PATTERN;
  - the rotation index is identical across all samples.
- After each SAMPLE the tap result updates a run tracker (cur_start, cur_len, best_start, best_len).
  - A strictly longer run replaces the best run, so on a tie the lowest-tap run wins.
  - Runs do not wrap from the last tap back to 0.
- After SAMPLE:
  - If tap < max: tap+1, go to LOAD.
  - Otherwise go to CENTER.
- CENTER:
  - If best_len < MIN_EYE: set fail_o[lane], go to NEXT_CHAN.
  - Otherwise compute centre = best_start + ((best_len-1)>>1) at DLY_BITS width (no overflow possible), then:
    - pulse the load at centre;
    - write eye_center_o;
    - wait SETTLE_CYCLES;
    - go to SLIP_CHECK.
- SLIP_CHECK:
  - word == TRAIN_PATTERN: set locked_o[lane], go to NEXT_CHAN.
  - Otherwise, if slips < 2*DWIDTH: bitslip_o[lane] pulses one cycle, slips+1, wait SLIP_WAIT cycles, re-check.
  - Otherwise set fail_o[lane], go to NEXT_CHAN.
- NEXT_CHAN:
  - lane+1, tap=0, run tracker and slip counter cleared, go to LOAD.
  - After lane NCHAN-1: done_o pulses, go to IDLE.
- Strobes are registered; at most one bit of idelay_load_o or bitslip_o is high in any cycle.
- locked_o and fail_o are mutually exclusive per lane and hold until the next start_i or reset.

Optional Feature:
- Macro: SURF_LINK_ALIGN_EYE_MAP_EN.
- Defined:
  - Adds output eye_map_o, width NCHAN*2**DLY_BITS.
  - Bit [n*2**DLY_BITS + t] is set when tap t of lane n was judged good.
  - The map is cleared on start_i and on reset.
- Undefined:
  - Port and storage are absent; all other behaviour is identical.

Test Plan:
- Lane 0 and lane 1 good at taps 10..19, data presented with rotation 3 → eye_center_o=14 per lane; exactly 3 bitslip pulses per lane; locked_o=2'b11; done_o pulses once.
- Lane 0 good at taps 2..5 and 20..23 (tie) → centre=3 (lowest run wins). Good taps 28..31 → centre=29 (no wrap, run ends at tap 31).
- Lane 1 good at taps 0..2 only (best_len=3 < MIN_EYE=4) → fail_o[1]=1, locked_o[1]=0, no bitslip on lane 1.
- Correct eye but no rotation ever yields 8'hA6 → exactly 16 bitslip pulses, then fail_o set.
- Word rotation changes within a SAMPLE window at tap 12 → tap 12 is not good; a second start_i during busy has no effect.
- rst_n_i low mid-sweep at tap 7 → all outputs 0 immediately; a later start_i restarts at lane 0, tap 0. With SURF_LINK_ALIGN_EYE_MAP_EN defined, eye_map_o matches the injected good taps.
